multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Parametrised multicycle successor to the single-cycle control decoder for the RV32I core.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states.
- Stalls on a cache ready handshake (MemReady) for instruction fetch, load and store.
- Adds a memory-wait timeout with a BusError pulse, and an Illegal pulse on unsupported opcodes.

Parameters:
- OP_W, 7, opcode field width.
- MEM_TIMEOUT, 64, maximum cycles spent waiting on MemReady in one state before abort. 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1), wait-counter width. Derived; do not override.

Ports:
- CLK  in  1  single clock.
- RST  in  1  synchronous active-low reset.
- OP  in  OP_W  opcode of the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  cache done: fetch or load data valid, or store accepted.
- PCWrite  out  1  PC load = PCUpdate | (Branch & Zero).
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  latch instruction register and OldPC.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A mux: 00 PC, 01 OldPC, 10 RD1.
- ALUSrcB  out  2  ALU B mux: 00 RD2, 01 ImmExt, 10 constant 4.
- ALUOp  out  2  ALU op class: 00 add, 01 sub, 10 funct decode.
- ImmSrc  out  3  immediate format: 000 I, 001 S, 010 B, 011 J.
- Illegal  out  1  one-cycle pulse on unsupported opcode.
- BusError  out  1  one-cycle pulse on memory-wait timeout.
- State  out  4  current state encoding, for debug.

Behaviour:
- Moore FSM with registered state and wait counter cnt; outputs are combinational from state. Exceptions:
  - PCWrite also depends on Zero.
  - IRWrite and PCUpdate in FETCH are gated by MemReady.
  - ImmSrc decodes combinationally from OP in every state: lw/I 000, sw 001, beq 010, jal 011, otherwise 000.
- Any output not listed for a state is 0.
- Reset: while RST=0 at a rising edge, state is set to FETCH and cnt to 0. While RST=0, all strobes are forced to 0 (MemRead, MemWrite, IRWrite, RegWrite, PCWrite, Illegal, BusError). Reset mid-wait abandons the access with no BusError.
- Opcodes: lw 0000011, sw 0100011, R 0110011, I 0010011, jal 1101111, beq 1100011.
- FETCH (0): AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=PCUpdate=MemReady. Next: DECODE if MemReady, else stay.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch target). Next:
  - lw/sw → MEMADR; R → EXECR; I → EXECI; jal → JAL; beq → BEQ.
  - Other opcodes → ILLEGAL.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD for lw, MEMWRITE for sw.
- MEMREAD (3): ResultSrc=00, AdrSrc=1, MemRead=1. Next: MEMWB on MemReady.
- MEMWB (4): ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE (5): ResultSrc=00, AdrSrc=1, MemWrite=1, held until MemReady. Next: FETCH.
- EXECR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB (8): ResultSrc=00, RegWrite=1. Next: FETCH.
- JAL (9): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ (10): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- ILLEGAL (11): Illegal=1 for exactly one cycle, no other strobes. Next: FETCH. PC has already advanced by 4.
- Wait states are FETCH, MEMREAD and MEMWRITE:
  - cnt increments each cycle with MemReady=0 and clears on every state change.
  - If MEM_TIMEOUT>0, MemReady=0 and cnt==MEM_TIMEOUT-1: BusError=1 that cycle; next state FETCH, cnt cleared. IRWrite, PCWrite and RegWrite stay 0.
  - MemReady=1 in the same cycle as the timeout: MemReady wins, no BusError.
- Latency with MemReady returned in the request cycle (fetch takes 1 cycle):
  - lw 5 cycles; sw, R, I and jal 4 cycles; beq 3 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- RST=0 for 2 cycles, then release with MemReady=1 and OP=0110011 → State sequence 0,1,6,8,0. RegWrite=1 only in state 8; strobes all 0 during reset.
- lw with MemReady low 3 cycles in MEMREAD → State 0,1,2,3,3,3,3,4,0. MemRead=1 and AdrSrc=1 through all 4 state-3 cycles; RegWrite=1 with ResultSrc=01 in state 4.
- beq with Zero=1, then again with Zero=0 → PCWrite=1 in state 10 for the first, 0 for the second. ALUOp=01 and ImmSrc=010 in both.
- OP=0110111 (lui, unsupported) → DECODE goes to state 11; Illegal=1 for one cycle, then FETCH.
- MEM_TIMEOUT=4, MemReady held 0 in FETCH → BusError=1 in the 4th FETCH cycle and IRWrite stays 0. Then fetch restarts with cnt=0; MemReady=1 on cycle 4 suppresses BusError.
- RST=0 asserted in MEMWRITE mid-wait → next cycle State=0 and MemWrite=0, BusError never asserted.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing
// with MemReady stalls, memory-wait timeout and illegal-opcode pulse.
module multicycle_control_fsm #(
    parameter int OP_W        = 7,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [OP_W-1:0] OP,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [2:0]      ImmSrc,
    output logic            Illegal,
    output logic            BusError,
    output logic [3:0]      State
);

    localparam int CW = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    localparam logic [OP_W-1:0] OP_LW  = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R   = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I   = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_JAL = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(7'b1100011);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wait_st, timeout, pc_update, branch;

    // State and wait-counter registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, wait counter and Moore outputs decoded from state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        Illegal   = 1'b0;
        BusError  = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;

        wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                  (state_q == S_MEMWRITE);
        timeout = (MEM_TIMEOUT > 0) && wait_st && !MemReady &&
                  (cnt_q == TO_LAST);

        unique case (state_q)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                pc_update = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (OP == OP_LW || OP == OP_SW) state_d = S_MEMADR;
                else if (OP == OP_R)            state_d = S_EXECR;
                else if (OP == OP_I)            state_d = S_EXECI;
                else if (OP == OP_JAL)          state_d = S_JAL;
                else if (OP == OP_BEQ)          state_d = S_BEQ;
                else                            state_d = S_ILLEGAL;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (timeout) begin
            BusError = 1'b1;
            state_d  = S_FETCH;
        end else if (wait_st && !MemReady) begin
            cnt_d = cnt_q + CW'(1);
        end

        PCWrite = pc_update | (branch & Zero);

        if (!RST) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            PCWrite  = 1'b0;
            Illegal  = 1'b0;
            BusError = 1'b0;
        end
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 3'b000;
        if (OP == OP_SW)       ImmSrc = 3'b001;
        else if (OP == OP_BEQ) ImmSrc = 3'b010;
        else if (OP == OP_JAL) ImmSrc = 3'b011;
    end

    assign State = state_q;

endmodule
